// File: rtl/charlieplex_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : charlieplex_scanner_pkg
// Description : Shared types and size helpers for the charlieplex scanner.
//               The helpers derive the LED count, the LED index width and the
//               counter widths, so every file sizes its vectors the same way.
// Revision    : 1.0 - initial release
// ============================================================================
package charlieplex_scanner_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Number of LEDs addressable with a given pin count
    function automatic int led_count(input int pins);
        return pins * (pins - 1);
    endfunction

    // Width of a counter or index covering 0..n-1; never less than 1 bit
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the LED index bus for a given pin count
    function automatic int idx_bits(input int pins);
        return cnt_bits(led_count(pins));
    endfunction

endpackage
`default_nettype wire

// File: rtl/charlieplex_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : charlieplex_scanner_if
// Description : Host-side framebuffer write port plus the tristate pin driver
//               outputs of the charlieplex scanner. The master side is the
//               host / pad ring, the slave side is the scanner itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface charlieplex_scanner_if #(
    parameter int PINCOUNT = 8,
    parameter int PWMBITS  = 4
);
    import charlieplex_scanner_pkg::*;

    localparam int IDXBITS = idx_bits(PINCOUNT);

    logic                enable;
    logic                wr_en;
    logic [IDXBITS-1:0]  wr_addr;
    logic [PWMBITS-1:0]  wr_data;
    logic [PINCOUNT-1:0] out_en;
    logic [PINCOUNT-1:0] out_value;
    logic                frame_start;

    modport master (
        output enable, wr_en, wr_addr, wr_data,
        input  out_en, out_value, frame_start
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data,
        output out_en, out_value, frame_start
    );

endinterface
`default_nettype wire

// File: rtl/charlieplex_decode.sv
`default_nettype none
// ============================================================================
// Module      : charlieplex_decode
// Description : Combinational LED index -> pin drive decoder. The anode pin is
//               driven high, the cathode pin low, every other pin tristate.
//               With drive low (or an out-of-range index) all pins tristate.
// Revision    : 1.0 - initial release
// ============================================================================
module charlieplex_decode
    import charlieplex_scanner_pkg::*;
#(
    parameter int PINCOUNT = 8
) (
    input  logic [idx_bits(PINCOUNT)-1:0] idx,
    input  logic                          drive,
    output logic [PINCOUNT-1:0]           out_en,
    output logic [PINCOUNT-1:0]           out_value
);

    localparam int LEDCOUNT = led_count(PINCOUNT);

    int   w_anode;
    int   w_cathode;
    logic w_valid;

    // Split the index into anode and cathode; the cathode skips the anode pin
    always_comb begin
        w_anode   = int'(idx) / (PINCOUNT - 1);
        w_cathode = int'(idx) % (PINCOUNT - 1);
        if (w_cathode >= w_anode) begin
            w_cathode = w_cathode + 1;
        end
        w_valid   = drive && (int'(idx) < LEDCOUNT);
    end

    for (genvar p = 0; p < PINCOUNT; p++) begin : g_pin
        assign out_en[p]    = w_valid && ((w_anode == p) || (w_cathode == p));
        assign out_value[p] = w_valid && (w_anode == p);
    end

endmodule
`default_nettype wire

// File: rtl/charlieplex_scanner.sv
`default_nettype none
// ============================================================================
// Module      : charlieplex_scanner
// Description : Autonomous charlieplex LED matrix scanner. Holds a per-LED
//               brightness framebuffer and lights one LED at a time: each slot
//               is BLANK all-tristate cycles followed by a PWM drive window of
//               (2^PWMBITS-1)*PRESCALE cycles. Pin outputs are registered.
//               The bus interface must be instantiated with the same PINCOUNT
//               and PWMBITS as this module.
// Revision    : 1.0 - initial release
// ============================================================================
module charlieplex_scanner
    import charlieplex_scanner_pkg::*;
#(
    parameter int PINCOUNT = 8,
    parameter int PWMBITS  = 4,
    parameter int PRESCALE = 16,
    parameter int BLANK    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    charlieplex_scanner_if.slave   bus
);

    localparam int LEDCOUNT = led_count(PINCOUNT);
    localparam int IDXBITS  = idx_bits(PINCOUNT);
    localparam int BLKBITS  = cnt_bits(BLANK);
    localparam int PREBITS  = cnt_bits(PRESCALE);

    localparam logic [IDXBITS-1:0] c_last_idx  = IDXBITS'(LEDCOUNT - 1);
    localparam logic [BLKBITS-1:0] c_last_blk  = BLKBITS'(BLANK - 1);
    localparam logic [PREBITS-1:0] c_last_pre  = PREBITS'(PRESCALE - 1);
    // PWM steps run 0 .. 2^PWMBITS-2, so the top level is lit on every step
    localparam logic [PWMBITS-1:0] c_last_step = PWMBITS'((2 ** PWMBITS) - 2);

    state_t               r_state;
    state_t               w_next_state;
    logic [IDXBITS-1:0]   r_idx;
    logic [IDXBITS-1:0]   w_next_idx;
    logic [BLKBITS-1:0]   r_blk;
    logic [BLKBITS-1:0]   w_next_blk;
    logic [PREBITS-1:0]   r_pre;
    logic [PREBITS-1:0]   w_next_pre;
    logic [PWMBITS-1:0]   r_step;
    logic [PWMBITS-1:0]   w_next_step;
    logic                 w_latch;
    logic [PWMBITS-1:0]   r_level;
    logic [PWMBITS-1:0]   r_fb [LEDCOUNT];
    logic                 w_wr_ok;
    logic                 w_drive;
    logic                 w_frame_start;
    logic [PINCOUNT-1:0]  w_dec_en;
    logic [PINCOUNT-1:0]  w_dec_value;
    logic [PINCOUNT-1:0]  r_out_en;
    logic [PINCOUNT-1:0]  r_out_value;
    logic                 r_frame_start;

    // Sequencer next-state: enable low overrides every other transition
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_blk   = r_blk;
        w_next_pre   = r_pre;
        w_next_step  = r_step;
        w_latch      = 1'b0;
        if (!bus.enable) begin
            w_next_state = ST_IDLE;
            w_next_idx   = '0;
            w_next_blk   = '0;
            w_next_pre   = '0;
            w_next_step  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_BLANK;
                    w_next_idx   = '0;
                    w_next_blk   = '0;
                    w_next_pre   = '0;
                    w_next_step  = '0;
                end
                ST_BLANK: begin
                    if (r_blk == c_last_blk) begin
                        w_latch      = 1'b1;
                        w_next_state = ST_DRIVE;
                        w_next_blk   = '0;
                        w_next_pre   = '0;
                        w_next_step  = '0;
                    end else begin
                        w_next_blk = r_blk + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (r_pre == c_last_pre) begin
                        w_next_pre = '0;
                        if (r_step == c_last_step) begin
                            w_next_state = ST_BLANK;
                            w_next_step  = '0;
                            w_next_idx   = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                        end else begin
                            w_next_step = r_step + 1'b1;
                        end
                    end else begin
                        w_next_pre = r_pre + 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_blk   <= '0;
            r_pre   <= '0;
            r_step  <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_blk   <= w_next_blk;
            r_pre   <= w_next_pre;
            r_step  <= w_next_step;
        end
    end

    assign w_wr_ok = bus.wr_en && (int'(bus.wr_addr) < LEDCOUNT);

    // Framebuffer write port; contents survive reset, out-of-range writes dropped
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_fb[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Framebuffer read port: level is sampled on the last blank cycle, so a
    // same-cycle write to this LED lands after the read and waits a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else if (w_latch) begin
            r_level <= r_fb[r_idx];
        end
    end

    assign w_drive       = (r_state == ST_DRIVE) && (r_step < r_level);
    assign w_frame_start = (r_state == ST_BLANK) && (r_blk == '0) && (r_idx == '0);

    charlieplex_decode #(
        .PINCOUNT (PINCOUNT)
    ) u_decode (
        .idx       (r_idx),
        .drive     (w_drive),
        .out_en    (w_dec_en),
        .out_value (w_dec_value)
    );

    // Registered pin drivers; dropping enable tristates on the very next cycle
    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            r_out_en      <= '0;
            r_out_value   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_out_en      <= w_dec_en;
            r_out_value   <= w_dec_value;
            r_frame_start <= w_frame_start;
        end
    end

    assign bus.out_en      = r_out_en;
    assign bus.out_value   = r_out_value;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_charlieplex_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_charlieplex_scanner
// Description : Self-checking bench for charlieplex_scanner with 4 pins,
//               2-bit PWM, no prescale and one blank cycle: 12 LEDs, 4-cycle
//               slots, 48-cycle frames. Outputs are sampled on the falling
//               edge; inputs are changed on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_charlieplex_scanner;

    localparam int PINCOUNT = 4;
    localparam int PWMBITS  = 2;
    localparam int PRESCALE = 1;
    localparam int BLANK    = 1;
    localparam int NLED     = 12;

    typedef struct {
        logic [3:0] en;
        logic [3:0] val;
    } map_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   pair_hits [16];
    bit   track;
    map_t map_tab [NLED];

    charlieplex_scanner_if #(.PINCOUNT(PINCOUNT), .PWMBITS(PWMBITS)) bus ();

    charlieplex_scanner #(
        .PINCOUNT (PINCOUNT),
        .PWMBITS  (PWMBITS),
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: wait for the falling edge, then compare all outputs
    task automatic cyc(input string tag, input logic [3:0] en, input logic [3:0] val, input logic fs);
        int a;
        int c;
        @(negedge clk);
        check($sformatf("%s out_en", tag), 32'(bus.out_en), 32'(en));
        check($sformatf("%s out_value", tag), 32'(bus.out_value), 32'(val));
        check($sformatf("%s frame_start", tag), 32'(bus.frame_start), 32'(fs));
        check($sformatf("%s pin count 0 or 2", tag),
              32'((bus.out_en == 4'b0000) || ($countones(bus.out_en) == 2)), 32'd1);
        if (track && (bus.out_en != 4'b0000)) begin
            a = -1;
            c = -1;
            for (int p = 0; p < PINCOUNT; p++) begin
                if (bus.out_en[p] && bus.out_value[p])  a = p;
                if (bus.out_en[p] && !bus.out_value[p]) c = p;
            end
            if (a >= 0 && c >= 0) pair_hits[a * 4 + c]++;
        end
    endtask

    // One LED slot: a blank cycle, then three PWM steps lit while step < level
    task automatic run_slot(input int idx, input int level, input logic fs);
        cyc($sformatf("idx%0d blank", idx), 4'b0000, 4'b0000, fs);
        for (int s = 0; s < 3; s++) begin
            if (s < level)
                cyc($sformatf("idx%0d step%0d", idx, s), map_tab[idx].en, map_tab[idx].val, 1'b0);
            else
                cyc($sformatf("idx%0d step%0d", idx, s), 4'b0000, 4'b0000, 1'b0);
        end
    endtask

    // Framebuffer write while the scanner is idle
    task automatic idle_write(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = 2'(data);
        cyc("idle write", 4'b0000, 4'b0000, 1'b0);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        // idx -> {out_en, out_value}; anode = idx/3, cathode = k or k+1
        map_tab[0]  = '{4'b0011, 4'b0001};
        map_tab[1]  = '{4'b0101, 4'b0001};
        map_tab[2]  = '{4'b1001, 4'b0001};
        map_tab[3]  = '{4'b0011, 4'b0010};
        map_tab[4]  = '{4'b0110, 4'b0010};
        map_tab[5]  = '{4'b1010, 4'b0010};
        map_tab[6]  = '{4'b0101, 4'b0100};
        map_tab[7]  = '{4'b0110, 4'b0100};
        map_tab[8]  = '{4'b1100, 4'b0100};
        map_tab[9]  = '{4'b1001, 4'b1000};
        map_tab[10] = '{4'b1010, 4'b1000};
        map_tab[11] = '{4'b1100, 4'b1000};

        checks = 0;
        errors = 0;
        track  = 1'b0;
        foreach (pair_hits[i]) pair_hits[i] = 0;

        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        cyc("reset", 4'b0000, 4'b0000, 1'b0);
        cyc("reset", 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;

        // Mapping sweep and framing: all LEDs at full level, three frames
        for (int i = 0; i < NLED; i++) idle_write(i, 3);
        track      = 1'b1;
        bus.enable = 1'b1;
        cyc("enable edge", 4'b0000, 4'b0000, 1'b0);
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < NLED; i++)
                run_slot(i, 3, i == 0);
        track = 1'b0;
        for (int a = 0; a < PINCOUNT; a++)
            for (int c = 0; c < PINCOUNT; c++)
                check($sformatf("pair a%0d c%0d hits", a, c),
                      32'(pair_hits[a * 4 + c]), (a != c) ? 32'd9 : 32'd0);

        // Enable drop in the middle of idx 7 drive
        for (int i = 0; i < 7; i++) run_slot(i, 3, i == 0);
        cyc("idx7 blank", 4'b0000, 4'b0000, 1'b0);
        cyc("idx7 step0", map_tab[7].en, map_tab[7].val, 1'b0);
        bus.enable = 1'b0;
        cyc("enable drop", 4'b0000, 4'b0000, 1'b0);
        cyc("disabled", 4'b0000, 4'b0000, 1'b0);

        // PWM levels after re-enable
        for (int i = 0; i < 4; i++) idle_write(i, i);
        bus.enable = 1'b1;
        cyc("re-enable edge", 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) run_slot(i, i, i == 0);

        // Restore idx 2 to full level for the write-hazard slot
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd2;
        bus.wr_data = 2'd3;
        run_slot(4, 3, 1'b0);
        bus.wr_en   = 1'b0;
        for (int i = 5; i < NLED; i++) run_slot(i, 3, 1'b0);
        run_slot(0, 0, 1'b1);
        run_slot(1, 1, 1'b0);

        // Write hazards: current-slot write, ignored address, write at latch
        cyc("idx2 blank", 4'b0000, 4'b0000, 1'b0);
        cyc("idx2 step0", map_tab[2].en, map_tab[2].val, 1'b0);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd2;
        bus.wr_data = 2'd0;
        cyc("idx2 step1", map_tab[2].en, map_tab[2].val, 1'b0);
        bus.wr_addr = 4'd12;
        bus.wr_data = 2'd3;
        cyc("idx2 step2", map_tab[2].en, map_tab[2].val, 1'b0);
        bus.wr_addr = 4'd3;
        bus.wr_data = 2'd0;
        run_slot(3, 3, 1'b0);
        bus.wr_en   = 1'b0;
        for (int i = 4; i < NLED; i++) run_slot(i, 3, 1'b0);
        run_slot(0, 0, 1'b1);
        run_slot(1, 1, 1'b0);
        run_slot(2, 0, 1'b0);
        run_slot(3, 0, 1'b0);

        // Reset in the middle of idx 4 drive; framebuffer must survive
        cyc("idx4 blank", 4'b0000, 4'b0000, 1'b0);
        cyc("idx4 step0", map_tab[4].en, map_tab[4].val, 1'b0);
        rst = 1'b1;
        cyc("mid reset", 4'b0000, 4'b0000, 1'b0);
        cyc("mid reset hold", 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        cyc("reset release", 4'b0000, 4'b0000, 1'b0);
        run_slot(0, 0, 1'b1);
        run_slot(1, 1, 1'b0);
        run_slot(2, 0, 1'b0);
        run_slot(3, 0, 1'b0);
        run_slot(4, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
